// File: rtl/reg_bus_master.sv
// Register-file bus initiator: turns READ/WRITE/CLEAR requests into W/ON/ADDR/DATA_IN
// sequences and returns read data or status on a response channel.
module reg_bus_master #(
  parameter int word_size   = 16,
  parameter int memory_size = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 REQ_VALID,
  output logic                 REQ_READY,
  input  logic [1:0]           REQ_OP,
  input  logic [word_size-1:0] REQ_ADDR,
  input  logic [word_size-1:0] REQ_DATA,
  output logic                 RSP_VALID,
  input  logic                 RSP_READY,
  output logic [word_size-1:0] RSP_DATA,
  output logic                 RSP_ERR,
  output logic                 REG_W,
  output logic                 REG_ON,
  output logic [word_size-1:0] REG_ADDR,
  output logic [word_size-1:0] REG_DIN,
  input  logic [word_size-1:0] REG_DOUT,
  output logic                 BUSY
);

  // Handshakes: a request transfers on a rising edge with REQ_VALID && REQ_READY, a
  // response transfers on a rising edge with RSP_VALID && RSP_READY; a side holding
  // VALID keeps its payload stable until the transfer edge.

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  localparam logic [word_size-1:0] LAST_ADDR = word_size'(memory_size - 1);
  localparam logic [word_size-1:0] ADDR_STEP = word_size'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_CLEAR,
    ST_RESP
  } state_t;

  // Kept as a named register so checkers can bind to it hierarchically.
  state_t state;

  logic req_fire;
  logic req_rw;
  logic req_in_range;

  assign req_fire     = REQ_VALID && REQ_READY;
  assign req_rw       = (REQ_OP == OP_READ) || (REQ_OP == OP_WRITE);
  assign req_in_range = (REQ_ADDR <= LAST_ADDR);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      REQ_READY <= 1'b1;
      RSP_VALID <= 1'b0;
      RSP_DATA  <= '0;
      RSP_ERR   <= 1'b0;
      REG_W     <= 1'b0;
      REG_ON    <= 1'b0;
      REG_ADDR  <= '0;
      REG_DIN   <= '0;
      BUSY      <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_fire) begin
            REQ_READY <= 1'b0;
            BUSY      <= 1'b1;
            // The bus registers double as the request latch for the access.
            if (req_rw && req_in_range) begin
              state    <= ST_ACCESS;
              REG_ON   <= 1'b1;
              REG_W    <= (REQ_OP == OP_WRITE);
              REG_ADDR <= REQ_ADDR;
              REG_DIN  <= (REQ_OP == OP_WRITE) ? REQ_DATA : '0;
            end else if (REQ_OP == OP_CLEAR) begin
              state    <= ST_CLEAR;
              REG_ON   <= 1'b1;
              REG_W    <= 1'b1;
              REG_ADDR <= '0;
              REG_DIN  <= '0;
            end else begin
              state     <= ST_RESP;
              RSP_VALID <= 1'b1;
              RSP_ERR   <= 1'b1;
              RSP_DATA  <= '0;
            end
          end
        end

        ST_ACCESS: begin
          state     <= ST_RESP;
          REG_ON    <= 1'b0;
          REG_W     <= 1'b0;
          RSP_DATA  <= REG_W ? '0 : REG_DOUT;
          RSP_ERR   <= 1'b0;
          RSP_VALID <= 1'b1;
        end

        ST_CLEAR: begin
          if (REG_ADDR >= LAST_ADDR) begin
            state     <= ST_RESP;
            REG_ON    <= 1'b0;
            REG_W     <= 1'b0;
            RSP_DATA  <= '0;
            RSP_ERR   <= 1'b0;
            RSP_VALID <= 1'b1;
          end else begin
            REG_ADDR <= REG_ADDR + ADDR_STEP;
          end
        end

        ST_RESP: begin
          if (RSP_READY) begin
            state     <= ST_IDLE;
            RSP_VALID <= 1'b0;
            RSP_DATA  <= '0;
            RSP_ERR   <= 1'b0;
            REQ_READY <= 1'b1;
            BUSY      <= 1'b0;
          end
        end

        default: begin
          state     <= ST_IDLE;
          REQ_READY <= 1'b1;
          RSP_VALID <= 1'b0;
          REG_ON    <= 1'b0;
          REG_W     <= 1'b0;
          BUSY      <= 1'b0;
        end
      endcase
    end
  end

endmodule
